// File: rtl/rx_byte_fifo_pkg.sv
// Shared UART receive-path types and default sizes.
// Imported by the rx_byte_fifo slice (interface, RAM and top).
package uart_pkg;

    localparam int UART_DATA_WIDTH       = 8;
    localparam int RX_FIFO_DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        CAPTURE = 2'd2
    } rx_cap_state_t;

endpackage

// File: rtl/rx_byte_fifo_if.sv
// Show-ahead valid/ready byte channel from the receive FIFO to its consumer.
interface rx_byte_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;

    modport master (
        output rd_data,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );

endinterface

// File: rtl/rx_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read.
module rx_fifo_ram
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = UART_DATA_WIDTH,
    parameter  int DEPTH      = RX_FIFO_DEFAULT_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rx_byte_fifo.sv
// Captures each byte from the RS-232 receiver into a circular FIFO with sticky overrun.
// Build option: define RX_FIFO_OVERWRITE_EN to overwrite the oldest byte when full.
module rx_byte_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = UART_DATA_WIDTH,
    parameter  int DEPTH      = RX_FIFO_DEFAULT_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_busy,
    rx_byte_fifo_if.master        rd_if,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  overrun,
    input  logic                  overrun_clear
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_BUSY    = BUSY;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [1:0]            state;
    logic                  busy_q;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_nxt;
    logic [ADDR_WIDTH:0]   rd_ptr_nxt;
    logic                  rd_valid_r;
    logic                  wr_req;
    logic                  pop;
    logic                  wr_en;
    logic                  rd_adv;
    logic                  ovr_set;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Capture FSM: a frame starts on a busy rise seen out of reset; busy_q comes
    // out of reset high so a frame already in flight at reset is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            busy_q <= 1'b1;
        end else begin
            busy_q <= rx_busy;
            case (state)
                ST_IDLE:    if (rx_busy && !busy_q) state <= ST_BUSY;
                ST_BUSY:    if (!rx_busy) state <= ST_CAPTURE;
                ST_CAPTURE: state <= rx_busy ? ST_BUSY : ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // The receiver's byte settles one clock after busy drops, hence the CAPTURE cycle.
    assign wr_req = (state == ST_CAPTURE);
    assign pop    = rd_valid_r && rd_if.rd_ready;

    always_comb begin
        ovr_set = wr_req && full && !pop;
`ifdef RX_FIFO_OVERWRITE_EN
        wr_en   = wr_req;
        rd_adv  = pop || ovr_set;
`else
        wr_en   = wr_req && (!full || pop);
        rd_adv  = pop;
`endif
    end

    assign wr_ptr_nxt = wr_en  ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_ptr_nxt = rd_adv ? rd_ptr + PTR_ONE : rd_ptr;

    // Pointer and flag stage: level/full/valid are registered from next-state pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            full       <= 1'b0;
            rd_valid_r <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            level      <= wr_ptr_nxt - rd_ptr_nxt;
            full       <= (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                          (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
            rd_valid_r <= (wr_ptr_nxt != rd_ptr_nxt);
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end
        end
    end

    rx_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    // Masking keeps rd_data at zero whenever nothing is stored, including after reset.
    assign rd_if.rd_data  = rd_valid_r ? ram_rd_data : '0;
    assign rd_if.rd_valid = rd_valid_r;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Randomised and directed bench for rx_byte_fifo against a queue-based reference model.
module tb_rx_byte_fifo;
    import uart_pkg::*;

    localparam int DW    = UART_DATA_WIDTH;
    localparam int DEPTH = RX_FIFO_DEFAULT_DEPTH;
    localparam int AW    = $clog2(DEPTH);

    logic          clk           = 1'b0;
    logic          reset         = 1'b0;
    logic [DW-1:0] rx_data       = '0;
    logic          rx_busy       = 1'b0;
    logic          overrun_clear = 1'b0;
    logic [AW:0]   level;
    logic          full;
    logic          overrun;

    rx_byte_fifo_if #(.DATA_WIDTH(DW)) rd_if ();

    rx_byte_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_busy       (rx_busy),
        .rd_if         (rd_if),
        .level         (level),
        .full          (full),
        .overrun       (overrun),
        .overrun_clear (overrun_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stored bytes as a plain queue plus sticky overrun.
    logic [DW-1:0] mq[$];
    bit            m_ovr       = 1'b0;
    bit            m_prev_busy = 1'b1;
    bit            m_in_frame  = 1'b0;
    bit            m_pend      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_ovr       = 1'b0;
                m_prev_busy = 1'b1;
                m_in_frame  = 1'b0;
                m_pend      = 1'b0;
            end else begin
                bit pop_m;
                bit ovf;
                pop_m = (mq.size() != 0) && rd_if.rd_ready;
                ovf   = 1'b0;
                if (pop_m) void'(mq.pop_front());
                if (m_pend) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(rx_data);
                    end else begin
                        ovf = 1'b1;
`ifdef RX_FIFO_OVERWRITE_EN
                        void'(mq.pop_front());
                        mq.push_back(rx_data);
`endif
                    end
                end
                if (ovf) m_ovr = 1'b1;
                else if (overrun_clear) m_ovr = 1'b0;
                m_pend = 1'b0;
                if (!m_prev_busy && rx_busy) m_in_frame = 1'b1;
                if (m_prev_busy && !rx_busy && m_in_frame) begin
                    m_pend     = 1'b1;
                    m_in_frame = 1'b0;
                end
                m_prev_busy = rx_busy;
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("rd_valid", 32'(rd_if.rd_valid), 32'(mq.size() != 0));
            check("level",    32'(level),          32'(mq.size()));
            check("full",     32'(full),           32'(mq.size() == DEPTH));
            check("overrun",  32'(overrun),        32'(m_ovr));
            if (mq.size() != 0) check("rd_data", 32'(rd_if.rd_data), 32'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] b, input int busy_len, input int gap,
                              input bit ready_on_cap);
        rx_busy = 1'b1;
        repeat (busy_len) tick();
        rx_busy = 1'b0;
        tick();
        rx_data = b;
        if (ready_on_cap) rd_if.rd_ready = 1'b1;
        tick();
        if (ready_on_cap) rd_if.rd_ready = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain();
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && rd_if.rd_valid; i++) tick();
        rd_if.rd_ready = 1'b0;
        check("drain_empty", 32'(rd_if.rd_valid), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"},   32'(rd_if.rd_valid), 32'd0);
        check({tag, "_level"},   32'(level),          32'd0);
        check({tag, "_full"},    32'(full),           32'd0);
        check({tag, "_overrun"}, 32'(overrun),        32'd0);
        check({tag, "_data"},    32'(rd_if.rd_data),  32'd0);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_if.rd_ready = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;
        repeat (3) tick();
        check("idle_no_write", 32'(level), 32'd0);

        // Single frame with a long busy period.
        send_frame(8'hA5, 20, 0, 1'b0);
        check("single_valid", 32'(rd_if.rd_valid), 32'd1);
        check("single_data",  32'(rd_if.rd_data),  32'hA5);
        check("single_level", 32'(level),          32'd1);
        rd_if.rd_ready = 1'b1;
        tick();
        rd_if.rd_ready = 1'b0;
        check("pop_valid", 32'(rd_if.rd_valid), 32'd0);
        check("pop_level", 32'(level),          32'd0);

        // Fill, overflow with 8'hEE, drain, then wrap the pointers.
        for (int i = 0; i < DEPTH; i++) send_frame(DW'(i), 3, 1, 1'b0);
        check("fill_full",  32'(full),  32'd1);
        check("fill_level", 32'(level), 32'(DEPTH));
        send_frame(8'hEE, 3, 1, 1'b0);
        check("ovf_flag",  32'(overrun), 32'd1);
        check("ovf_level", 32'(level),   32'(DEPTH));
        drain();
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        check("ovf_clear", 32'(overrun), 32'd0);
        for (int i = 16; i < 24; i++) send_frame(DW'(i), 2, 0, 1'b0);
        check("wrap_level", 32'(level), 32'd8);
        drain();

        // Capture coinciding with a pop while full.
        for (int i = 0; i < DEPTH; i++) send_frame(DW'(8'h30 + i), 2, 1, 1'b0);
        send_frame(8'h5A, 2, 0, 1'b1);
        check("simul_level",   32'(level),   32'(DEPTH));
        check("simul_overrun", 32'(overrun), 32'd0);
        drain();

        // Random traffic with a slow consumer and occasional overrun clears.
        fork
            begin
                for (int f = 0; f < 40; f++)
                    send_frame(DW'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 1'b0);
            end
            begin
                for (int c = 0; c < 400; c++) begin
                    rd_if.rd_ready = ($urandom_range(0, 3) == 0);
                    overrun_clear  = ($urandom_range(0, 15) == 0);
                    tick();
                end
            end
        join
        overrun_clear = 1'b0;
        drain();

        // Reset in the middle of a frame with three bytes stored.
        for (int i = 0; i < 3; i++) send_frame(DW'(8'hC0 + i), 2, 1, 1'b0);
        check("pre_reset_level", 32'(level), 32'd3);
        rx_busy = 1'b1;
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) tick();
        rx_busy = 1'b0;
        repeat (4) tick();
        check("post_reset_level", 32'(level),          32'd0);
        check("post_reset_valid", 32'(rd_if.rd_valid), 32'd0);

        // A normal frame after the discarded one still lands.
        send_frame(8'h3C, 3, 1, 1'b0);
        check("after_reset_data", 32'(rd_if.rd_data), 32'h3C);
        drain();

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
